// File: rtl/truth_table_scanner.sv
// Drives {a,b,c} through all 8 combinations, samples the gate output after a
// settle delay and checks the captured truth table. Optional: SCANNER_FIRST_FAIL_EN.
module truth_table_scanner #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXPECTED      = 8'hFE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match
`ifdef SCANNER_FIRST_FAIL_EN
  ,
  output logic       fail_valid,
  output logic [2:0] first_fail
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] table_q, table_d;
  logic       match_q, match_d;
`ifdef SCANNER_FIRST_FAIL_EN
  logic       fail_q, fail_d;
  logic [2:0] ffidx_q, ffidx_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      match_q <= 1'b0;
`ifdef SCANNER_FIRST_FAIL_EN
      fail_q  <= 1'b0;
      ffidx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      match_q <= match_d;
`ifdef SCANNER_FIRST_FAIL_EN
      fail_q  <= fail_d;
      ffidx_q <= ffidx_d;
`endif
    end
  end

  // Outputs are registered copies of what the next state will present, so
  // {a,b,c}, busy and done change on the same edge as the state transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abc_d   = abc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    match_d = match_q;
`ifdef SCANNER_FIRST_FAIL_EN
    fail_d  = fail_q;
    ffidx_d = ffidx_q;
`endif

    case (state_q)
      IDLE: begin
        abc_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          idx_d   = '0;
          cnt_d   = SETTLE_INIT;
          table_d = '0;
          match_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SETTLE;
`ifdef SCANNER_FIRST_FAIL_EN
          fail_d  = 1'b0;
          ffidx_d = '0;
`endif
        end
      end

      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          table_d[idx_q] = s_in;
`ifdef SCANNER_FIRST_FAIL_EN
          if ((s_in != EXPECTED[idx_q]) && !fail_q) begin
            fail_d  = 1'b1;
            ffidx_d = idx_q;
          end
`endif
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
            cnt_d = SETTLE_INIT;
            abc_d = idx_q + 3'd1;
          end else begin
            // Final bit is folded in directly so match is valid alongside done.
            match_d = ({s_in, table_q[6:0]} == EXPECTED);
            abc_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign {a, b, c}  = abc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign match      = match_q;
`ifdef SCANNER_FIRST_FAIL_EN
  assign fail_valid = fail_q;
  assign first_fail = ffidx_q;
`endif

endmodule
